// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flag indices and FSM encoding for alu_seq
package alu_pkg;

  localparam logic [3:0] MODE_NOP    = 4'h0;
  localparam logic [3:0] MODE_ADD    = 4'h1;
  localparam logic [3:0] MODE_SUB    = 4'h2;
  localparam logic [3:0] MODE_NAND   = 4'h3;
  localparam logic [3:0] MODE_SHL    = 4'h4;
  localparam logic [3:0] MODE_SHR    = 4'h5;
  localparam logic [3:0] MODE_PASSA  = 4'h6;
  localparam logic [3:0] MODE_PASSA2 = 4'h7;
  localparam logic [3:0] MODE_PASSB  = 4'h8;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - iterative one-bit-per-clock logical shifter
// done/data_out/last_out are combinational so the caller can capture the final step on the same edge.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dir,
  input  logic [SHAMT_W-1:0] amount,
  input  logic [WIDTH-1:0]   data_in,
  output logic               done,
  output logic [WIDTH-1:0]   data_out,
  output logic               last_out
);

  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] count;
  logic               dir_q;

  assign data_out = (dir_q == SHIFT_RIGHT) ? {1'b0, work[WIDTH-1:1]} : {work[WIDTH-2:0], 1'b0};
  assign last_out = (dir_q == SHIFT_RIGHT) ? work[0] : work[WIDTH-1];
  assign done     = (count == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      work  <= '0;
      count <= '0;
      dir_q <= SHIFT_LEFT;
    end else if (start) begin
      work  <= data_in;
      count <= amount;
      dir_q <= dir;
    end else if (count != '0) begin
      work  <= data_out;
      count <= count - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered WIDTH-bit ALU with valid/ready input and persistent {Z,N,C,V}
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [0:0]         state;
  logic               accept;
  logic               upd;
  logic               zn_upd;
  logic               sh_start;
  logic               sh_done;
  logic               sh_last;
  logic [WIDTH-1:0]   sh_out;
  logic [WIDTH-1:0]   res_n;
  logic [3:0]         flg_n;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [SHAMT_W-1:0] shamt;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign shamt    = b[SHAMT_W-1:0];
  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};

  alu_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .start    (sh_start),
    .dir      ((mode == MODE_SHR) ? SHIFT_RIGHT : SHIFT_LEFT),
    .amount   (shamt),
    .data_in  (a),
    .done     (sh_done),
    .data_out (sh_out),
    .last_out (sh_last)
  );

  always_comb begin
    upd      = 1'b0;
    zn_upd   = 1'b0;
    sh_start = 1'b0;
    res_n    = result;
    flg_n    = flags;
    if (accept) begin
      case (mode)
        MODE_ADD: begin
          upd = 1'b1; zn_upd = 1'b1;
          res_n = sum[WIDTH-1:0];
          flg_n[FLAG_C] = sum[WIDTH];
          flg_n[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
        MODE_SUB: begin
          upd = 1'b1; zn_upd = 1'b1;
          res_n = diff[WIDTH-1:0];
          flg_n[FLAG_C] = diff[WIDTH];
          flg_n[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end
        MODE_NAND: begin
          upd = 1'b1; zn_upd = 1'b1;
          res_n = ~(a & b);
        end
        MODE_SHL, MODE_SHR: begin
          if (shamt == '0) begin
            upd = 1'b1; zn_upd = 1'b1;
            res_n = a;
          end else begin
            sh_start = 1'b1;
          end
        end
        MODE_PASSA, MODE_PASSA2: begin
          upd = 1'b1;
          res_n = a;
        end
        MODE_PASSB: begin
          upd = 1'b1;
          res_n = b;
        end
        default: ;
      endcase
    end
    // in_ready is low throughout SHIFT, so completion never collides with an accept
    if (state == ST_SHIFT && sh_done) begin
      upd = 1'b1; zn_upd = 1'b1;
      res_n = sh_out;
      flg_n[FLAG_C] = sh_last;
    end
    if (zn_upd) begin
      flg_n[FLAG_Z] = (res_n == '0);
      flg_n[FLAG_N] = res_n[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      result    <= '0;
      flags     <= 4'b0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= upd;
      if (upd) begin
        result <= res_n;
        flags  <= flg_n;
      end
      if (sh_start)
        state <= ST_SHIFT;
      else if (state == ST_SHIFT && sh_done)
        state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH=8 and WIDTH=16
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v8, rdy8, ov8;
  logic [3:0]  md8, fl8;
  logic [7:0]  a8, b8, res8;
  logic        v16, rdy16, ov16;
  logic [3:0]  md16, fl16;
  logic [15:0] a16, b16, res16;

  int checks = 0;
  int failures = 0;

  alu_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .mode(md8),
    .a(a8), .b(b8), .out_valid(ov8), .result(res8), .flags(fl8)
  );

  alu_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .mode(md16),
    .a(a16), .b(b16), .out_valid(ov16), .result(res16), .flags(fl16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [3:0] m, input logic [7:0] x, input logic [7:0] y);
    v8 = 1'b1; md8 = m; a8 = x; b8 = y;
    step();
    v8 = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    rst = 1'b1;
    v8 = 0; md8 = 0; a8 = 0; b8 = 0;
    v16 = 0; md16 = 0; a16 = 0; b16 = 0;
    step(); step();
    rst = 1'b0;
    check("reset_ready", rdy8, 1);
    check("reset_result", res8, 0);
    check("reset_flags", fl8, 0);
    check("reset_valid", ov8, 0);

    op8(4'h1, 8'h7F, 8'h01);
    check("add_res", res8, 8'h80); check("add_flags", fl8, 4'b0101); check("add_ov", ov8, 1);
    op8(4'h2, 8'h05, 8'h05);
    check("sub_res", res8, 8'h00); check("sub_flags", fl8, 4'b1000); check("sub_ov", ov8, 1);
    step();
    check("ov_pulse", ov8, 0);

    op8(4'h4, 8'h81, 8'h03);
    check("shl_rdy0", rdy8, 0); check("shl_ov0", ov8, 0);
    step(); check("shl_rdy1", rdy8, 0);
    step(); check("shl_rdy2", rdy8, 0); check("shl_ov2", ov8, 0);
    step();
    check("shl_ov", ov8, 1); check("shl_res", res8, 8'h08);
    check("shl_flags", fl8, 4'b0000); check("shl_rdy_back", rdy8, 1);

    op8(4'h5, 8'h81, 8'h01);
    check("shr_rdy", rdy8, 0); check("shr_ov0", ov8, 0);
    step();
    check("shr_ov", ov8, 1); check("shr_res", res8, 8'h40); check("shr_flags", fl8, 4'b0010);

    op8(4'h2, 8'h00, 8'h01);
    check("sub_borrow_res", res8, 8'hFF); check("sub_borrow_flags", fl8, 4'b0110);
    op8(4'h3, 8'hFF, 8'hFF);
    check("nand_res", res8, 8'h00); check("nand_flags", fl8, 4'b1010);
    op8(4'h8, 8'h12, 8'h55);
    check("passb_res", res8, 8'h55); check("passb_flags", fl8, 4'b1010);
    op8(4'h0, 8'h01, 8'h02);
    check("nop_ov", ov8, 0); check("nop_res", res8, 8'h55);
    op8(4'hC, 8'h01, 8'h02);
    check("rsvd_ov", ov8, 0); check("rsvd_res", res8, 8'h55); check("rsvd_flags", fl8, 4'b1010);

    v8 = 1'b1;
    md8 = 4'h1; a8 = 8'h10; b8 = 8'h20; step();
    check("b2b_add_ov", ov8, 1); check("b2b_add_res", res8, 8'h30); check("b2b_add_flags", fl8, 4'b0000);
    md8 = 4'h2; step();
    check("b2b_sub_ov", ov8, 1); check("b2b_sub_res", res8, 8'hF0); check("b2b_sub_flags", fl8, 4'b0110);
    md8 = 4'h6; a8 = 8'h33; step();
    check("b2b_pass_ov", ov8, 1); check("b2b_pass_res", res8, 8'h33); check("b2b_pass_flags", fl8, 4'b0110);

    md8 = 4'h4; a8 = 8'h01; b8 = 8'h02; step();
    md8 = 4'h1; a8 = 8'h01; b8 = 8'h01;
    check("stall_rdy", rdy8, 0);
    step();
    check("stall_ov", ov8, 0); check("stall_res", res8, 8'h33);
    step();
    check("stall_shift_ov", ov8, 1); check("stall_shift_res", res8, 8'h04); check("stall_rdy_back", rdy8, 1);
    step();
    v8 = 1'b0;
    check("stall_add_ov", ov8, 1); check("stall_add_res", res8, 8'h02);

    op8(4'h2, 8'h00, 8'h01);
    op8(4'h4, 8'hFF, 8'h07);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_res", res8, 0); check("rst_mid_flags", fl8, 0);
    check("rst_mid_ov", ov8, 0); check("rst_mid_rdy", rdy8, 1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ov8) seen = 1'b1;
    end
    check("rst_no_late_ov", seen, 0);

    v16 = 1'b1; md16 = 4'h1; a16 = 16'hFFFF; b16 = 16'h0001; step(); v16 = 1'b0;
    check("w16_add_res", res16, 16'h0000); check("w16_add_flags", fl16, 4'b1010);
    v16 = 1'b1; md16 = 4'h5; a16 = 16'h8000; b16 = 16'h000F; step(); v16 = 1'b0;
    n = 0;
    while (!ov16 && n < 40) begin
      step();
      n++;
    end
    check("w16_shr_latency", n, 15);
    check("w16_shr_res", res16, 16'h0001);
    check("w16_shr_flags", fl16, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
